// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 integer register file of the RV32I pipeline.
// Define WB_RETIRE_CNT_EN to build in the 64-bit retired-instruction counter.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] data_wb,
  input  logic            memtoReg_wb,
  input  logic            regwrite_wb,
  input  logic [XLEN-1:0] alu_result_wb,
  input  logic [4:0]      rd_wb,
  input  logic [XLEN-1:0] pc_plus_4_wb,
  input  logic            jal_wb,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_result,
  output logic            wb_fwd_en
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_count
`endif
);

  logic [XLEN-1:0] regs [NREGS];
  logic            we;

  always_comb begin
    if (jal_wb)
      wb_result = pc_plus_4_wb;
    else if (memtoReg_wb)
      wb_result = data_wb;
    else
      wb_result = alu_result_wb;
  end

  assign we        = wb_valid & regwrite_wb & (rd_wb != 5'd0);
  assign wb_fwd_en = we;

  // rst_n is active-high here; x0 is cleared with the rest but never written.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[rd_wb] <= wb_result;
    end
  end

  // Write-through bypass stays live during reset; x0 is never bypassed.
  always_comb begin
    if (rs1_addr == 5'd0)
      rs1_data = '0;
    else if (we && (rs1_addr == rd_wb))
      rs1_data = wb_result;
    else
      rs1_data = regs[rs1_addr];
  end

  always_comb begin
    if (rs2_addr == 5'd0)
      rs2_data = '0;
    else if (we && (rs2_addr == rd_wb))
      rs2_data = wb_result;
    else
      rs2_data = regs[rs2_addr];
  end

`ifdef WB_RETIRE_CNT_EN
  // Counts every valid instruction, whether or not it writes rd.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      retire_count <= 64'd0;
    else if (wb_valid)
      retire_count <= retire_count + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, hand-written
// reset/counter sequences and randomized cycles against a register-array model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, memtoReg_wb, regwrite_wb, jal_wb;
  logic [31:0] data_wb, alu_result_wb, pc_plus_4_wb;
  logic [4:0]  rd_wb, rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_result;
  logic        wb_fwd_en;
  logic [63:0] retire_count_obs;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_count;
  assign retire_count_obs = retire_count;
`else
  assign retire_count_obs = 64'd0;
`endif

  wb_regfile #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .data_wb(data_wb),
    .memtoReg_wb(memtoReg_wb), .regwrite_wb(regwrite_wb),
    .alu_result_wb(alu_result_wb), .rd_wb(rd_wb), .pc_plus_4_wb(pc_plus_4_wb),
    .jal_wb(jal_wb), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_result(wb_result),
    .wb_fwd_en(wb_fwd_en)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic        rw;
    logic        mem;
    logic        jal;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] data;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [31:0] e_res;
    logic        e_fwd;
  } vec_t;

  vec_t        vecs [17];
  logic [31:0] model_regs [32];
  logic [63:0] model_count;
  int          tests_run    = 0;
  int          tests_failed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle's inputs just after a falling edge; async reset clears the model at once.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n         = v.rst;
    wb_valid      = v.valid;
    regwrite_wb   = v.rw;
    memtoReg_wb   = v.mem;
    jal_wb        = v.jal;
    rd_wb         = v.rd;
    alu_result_wb = v.alu;
    data_wb       = v.data;
    pc_plus_4_wb  = v.pc4;
    rs1_addr      = v.rs1;
    rs2_addr      = v.rs2;
    if (v.rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_count = 64'd0;
    end
    #1;
  endtask

  // Model of what the coming rising edge does.
  task automatic commitModel(input vec_t v);
    if (!v.rst) begin
      if (v.valid && v.rw && v.rd != 5'd0)
        model_regs[v.rd] = v.jal ? v.pc4 : (v.mem ? v.data : v.alu);
      if (v.valid) model_count = model_count + 64'd1;
    end
  endtask

  function automatic logic [31:0] modelRead(input vec_t v, input logic [4:0] a);
    logic [31:0] res;
    res = v.jal ? v.pc4 : (v.mem ? v.data : v.alu);
    if (a == 5'd0) return 32'd0;
    if (v.valid && v.rw && v.rd != 5'd0 && a == v.rd) return res;
    return model_regs[a];
  endfunction

  function automatic vec_t mk(input logic rst, valid, rw, mem, jal,
                              input logic [4:0] rd, input logic [31:0] alu, data, pc4,
                              input logic [4:0] rs1, rs2,
                              input logic [31:0] e1, e2, er, input logic ef);
    vec_t v;
    v = '{rst, valid, rw, mem, jal, rd, alu, data, pc4, rs1, rs2, e1, e2, er, ef};
    return v;
  endfunction

  initial begin
    vec_t v;
    rst_n = 1'b1; wb_valid = 0; regwrite_wb = 0; memtoReg_wb = 0; jal_wb = 0;
    rd_wb = 0; alu_result_wb = 0; data_wb = 0; pc_plus_4_wb = 0; rs1_addr = 0; rs2_addr = 0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_count = 64'd0;

    //              rst v rw m j  rd  alu           data   pc4    rs1 rs2  e_rs1         e_rs2         e_res         fwd
    vecs[0]  = mk(1, 0, 0, 0, 0, 0,  32'h0,        32'h0, 32'h0, 5,  0,  32'h0,        32'h0,        32'h0,        0);
    vecs[1]  = mk(0, 1, 1, 0, 0, 5,  32'hDEADBEEF, 32'h0, 32'h0, 5,  0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,  32'h0,        32'h0, 32'h0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0,  32'h0,        32'h0, 32'h0, 5,  0,  32'h0,        32'h0,        32'h0,        0);
    vecs[4]  = mk(1, 1, 1, 0, 0, 5,  32'h77,       32'h0, 32'h0, 5,  6,  32'h77,       32'h0,        32'h77,       1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0,  32'h0,        32'h0, 32'h0, 5,  5,  32'h0,        32'h0,        32'h0,        0);
    vecs[6]  = mk(0, 1, 1, 1, 1, 7,  32'h11,       32'h22, 32'h33, 7, 0, 32'h33,       32'h0,        32'h33,       1);
    vecs[7]  = mk(0, 1, 1, 1, 0, 7,  32'h11,       32'h22, 32'h33, 7, 7, 32'h22,       32'h22,       32'h22,       1);
    vecs[8]  = mk(0, 1, 1, 0, 0, 7,  32'h11,       32'h22, 32'h33, 7, 7, 32'h11,       32'h11,       32'h11,       1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0,  32'h0,        32'h0, 32'h0, 7,  5,  32'h11,       32'h0,        32'h0,        0);
    vecs[10] = mk(0, 1, 1, 0, 0, 0,  32'h1234,     32'h0, 32'h0, 0,  0,  32'h0,        32'h0,        32'h1234,     0);
    vecs[11] = mk(0, 1, 1, 0, 0, 3,  32'hA5A5A5A5, 32'h0, 32'h0, 3,  3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0,  32'h0,        32'h0, 32'h0, 3,  3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        0);
    vecs[13] = mk(0, 0, 1, 0, 0, 9,  32'h99,       32'h0, 32'h0, 9,  0,  32'h0,        32'h0,        32'h99,       0);
    vecs[14] = mk(0, 1, 0, 0, 0, 9,  32'h98,       32'h0, 32'h0, 9,  9,  32'h0,        32'h0,        32'h98,       0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0,  32'h0,        32'h0, 32'h0, 9,  7,  32'h0,        32'h11,       32'h0,        0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0,  32'h0,        32'h0, 32'h0, 0,  3,  32'h0,        32'hA5A5A5A5, 32'h0,        0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d rs1_data", i), {32'd0, rs1_data}, {32'd0, vecs[i].e_rs1});
      checkOutput($sformatf("vec%0d rs2_data", i), {32'd0, rs2_data}, {32'd0, vecs[i].e_rs2});
      checkOutput($sformatf("vec%0d wb_result", i), {32'd0, wb_result}, {32'd0, vecs[i].e_res});
      checkOutput($sformatf("vec%0d wb_fwd_en", i), {63'd0, wb_fwd_en}, {63'd0, vecs[i].e_fwd});
`ifdef WB_RETIRE_CNT_EN
      checkOutput($sformatf("vec%0d retire_count", i), retire_count_obs, model_count);
`endif
      commitModel(vecs[i]);
    end

`ifdef WB_RETIRE_CNT_EN
    // Wrap: load the counter with all ones, then retire one instruction.
    @(negedge clk);
    force dut.retire_count = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_count;
    model_count = 64'hFFFF_FFFF_FFFF_FFFF;
    v = mk(0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    applyStimulus(v);
    checkOutput("wrap preload", retire_count_obs, 64'hFFFF_FFFF_FFFF_FFFF);
    commitModel(v);
    v.valid = 1'b0;
    applyStimulus(v);
    checkOutput("wrap to zero", retire_count_obs, 64'd0);
    commitModel(v);
`endif

    for (int n = 0; n < 400; n++) begin
      v.rst   = ($urandom_range(0, 39) == 0);
      v.valid = ($urandom_range(0, 3) != 0);
      v.rw    = ($urandom_range(0, 3) != 0);
      v.mem   = $urandom_range(0, 1) == 1;
      v.jal   = ($urandom_range(0, 4) == 0);
      v.rd    = 5'($urandom_range(0, 31));
      v.alu   = $urandom;
      v.data  = $urandom;
      v.pc4   = $urandom;
      v.rs1   = ($urandom_range(0, 3) == 0) ? v.rd : 5'($urandom_range(0, 31));
      v.rs2   = ($urandom_range(0, 3) == 0) ? v.rd : 5'($urandom_range(0, 31));
      applyStimulus(v);
      checkOutput($sformatf("rand%0d rs1_data", n), {32'd0, rs1_data}, {32'd0, modelRead(v, v.rs1)});
      checkOutput($sformatf("rand%0d rs2_data", n), {32'd0, rs2_data}, {32'd0, modelRead(v, v.rs2)});
      checkOutput($sformatf("rand%0d wb_result", n), {32'd0, wb_result},
                  {32'd0, v.jal ? v.pc4 : (v.mem ? v.data : v.alu)});
      checkOutput($sformatf("rand%0d wb_fwd_en", n), {63'd0, wb_fwd_en},
                  {63'd0, v.valid & v.rw & (v.rd != 5'd0)});
`ifdef WB_RETIRE_CNT_EN
      checkOutput($sformatf("rand%0d retire_count", n), retire_count_obs, model_count);
`endif
      commitModel(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file of the 5-stage RV32I pipeline, sitting directly downstream of the MEM/WB pipeline register and consuming its `*_wb` outputs. It selects the writeback result, commits it to the 32×32 integer register file, and serves the decode stage's two read ports. Same-cycle writes are bypassed to the read ports, and an optional retired-instruction counter is provided.

## Interface
Parameters:
- XLEN, 32, data width of registers and result paths
- NREGS, 32, number of architectural registers; x0 is hardwired to zero

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-high
- wb_valid  in  1  a real instruction (not a bubble) occupies WB this cycle
- data_wb  in  XLEN  load data from MEM/WB
- memtoReg_wb  in  1  select load data as result
- regwrite_wb  in  1  instruction writes rd
- alu_result_wb  in  XLEN  ALU result from MEM/WB
- rd_wb  in  5  destination register index
- pc_plus_4_wb  in  XLEN  link value for JAL/JALR
- jal_wb  in  1  select link value as result
- rs1_addr, rs2_addr  in  5 each  decode-stage read indices
- rs1_data, rs2_data  out  XLEN each  read data, bypass applied
- wb_result  out  XLEN  selected writeback value, for forwarding to EX
- wb_fwd_en  out  1  wb_result is being written this cycle
- retire_count  out  64  retired-instruction count (only with WB_RETIRE_CNT_EN)

## Operation
- Result mux, priority: jal_wb → pc_plus_4_wb; else memtoReg_wb → data_wb; else alu_result_wb. Combinational; driven regardless of wb_valid.
- we = wb_valid & regwrite_wb & (rd_wb != 0). wb_fwd_en = we.
- Write: on posedge with we=1 and rst_n=0, regs[rd_wb] <= wb_result.
- x0: never written, always reads 0, never bypassed.
- Read port n: if rsn_addr == 0 → 0; else if we & rsn_addr == rd_wb → wb_result (write-through bypass); else regs[rsn_addr]. Both ports are fully independent; both may hit the bypass simultaneously.
- Retire counter (when compiled in): increments by 1 on each posedge with wb_valid=1 and rst_n=0, independent of regwrite_wb; wraps 2^64−1 → 0.
- Reset asserted (rst_n=1): regs x1..x31 and retire_count cleared to 0 immediately (asynchronous) and held; any write or increment on a concurrent edge is discarded. Outputs during reset: rsn_data = 0 unless bypass is active (bypass stays combinational), wb_result follows the mux, retire_count = 0.
- Reset deassertion mid-stream: the first posedge with rst_n=0 performs normal write/increment.

## Timing
- Write latency: 1 cycle (value visible from the array on the cycle after the edge); effective read-after-write latency 0 via bypass.
- Read path purely combinational: rsn_addr → rsn_data within the same cycle.
- wb_result/wb_fwd_en combinational from WB inputs; no internal pipeline stage.
- No stall or handshake input: MEM/WB already holds bubbles as wb_valid=0.

## Configuration
- WB_RETIRE_CNT_EN defined: 64-bit retire counter and retire_count port present as specified.
- Not defined: counter logic and retire_count port are removed entirely; all other behaviour identical.

## Test plan
- Reset: drive rst_n=1 after writing x5=0xDEADBEEF → rs1_addr=5 reads 0 immediately, retire_count=0; a write edge during reset leaves x5=0.
- Mux priority: valid, regwrite, rd=7, alu=0x11, data=0x22, pc+4=0x33 with jal=1,memtoReg=1 → x7=0x33; jal=0,memtoReg=1 → 0x22; both 0 → 0x11.
- x0 protection: write rd=0 value 0x1234 → rs1/rs2 at addr 0 read 0, wb_fwd_en=0.
- Bypass: rd=3 writing 0xA5A5A5A5, rs1_addr=rs2_addr=3 same cycle → both read 0xA5A5A5A5 before the edge; after edge, array read returns same value.
- Bubble/no-write: wb_valid=0 or regwrite_wb=0 with rd=9 → x9 unchanged, no bypass, counter increments only when wb_valid=1.
- Counter wrap (macro on): preload/force counter to 2^64−1, one valid cycle → retire_count=0.
